// File: rtl/add_seq_ctrl.sv
// Wide adder s = a + b + ci built from one shared 4-bit adder, one nibble per clock,
// LSB nibble first, with a start/busy/done handshake.
module fa4_mbit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_ci,
    output logic [3:0] o_s,
    output logic       o_co
);
    assign {o_co, o_s} = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_ci};
endmodule

module add_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   ci,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   s,
    output logic                   co
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          r_state;
    logic [W-1:0]    r_opa;
    logic [W-1:0]    r_opb;
    logic [W-1:0]    r_s;
    logic [IW-1:0]   r_idx;
    logic            r_cy;
    logic            r_co;
    logic            r_busy;
    logic            r_done;

    logic [3:0]      w_a;
    logic [3:0]      w_b;
    logic [3:0]      w_sum;
    logic            w_co;

    assign w_a = r_opa[4*r_idx +: 4];
    assign w_b = r_opb[4*r_idx +: 4];

    fa4_mbit u_fa (
        .i_a  (w_a),
        .i_b  (w_b),
        .i_ci (r_cy),
        .o_s  (w_sum),
        .o_co (w_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_opa   <= '0;
            r_opb   <= '0;
            r_s     <= '0;
            r_idx   <= '0;
            r_cy    <= 1'b0;
            r_co    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // Handshake outputs trail the state by one edge: done lands NIBBLES+1 edges after accept.
            r_busy <= (r_state != S_IDLE);
            r_done <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_opa   <= a;
                        r_opb   <= b;
                        r_cy    <= ci;
                        r_idx   <= '0;
                        r_s     <= '0;
                        r_co    <= 1'b0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_s[4*r_idx +: 4] <= w_sum;
                    r_cy              <= w_co;
                    if (r_idx == IW'(NIBBLES - 1)) begin
                        r_co    <= w_co;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign s    = r_s;
    assign co   = r_co;
endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl at NIBBLES = 2, 4 and 8.
module tb_add_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        st2 = 0, ci2 = 0, busy2, done2, co2;
    logic [7:0]  a2 = 0, b2 = 0, s2;
    logic        st4 = 0, ci4 = 0, busy4, done4, co4;
    logic [15:0] a4 = 0, b4 = 0, s4;
    logic        st8 = 0, ci8 = 0, busy8, done8, co8;
    logic [31:0] a8 = 0, b8 = 0, s8;

    add_seq_ctrl #(.NIBBLES(2)) u_n2 (.clk(clk), .rst(rst), .start(st2), .a(a2), .b(b2), .ci(ci2),
                                      .busy(busy2), .done(done2), .s(s2), .co(co2));
    add_seq_ctrl #(.NIBBLES(4)) u_n4 (.clk(clk), .rst(rst), .start(st4), .a(a4), .b(b4), .ci(ci4),
                                      .busy(busy4), .done(done4), .s(s4), .co(co4));
    add_seq_ctrl #(.NIBBLES(8)) u_n8 (.clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .ci(ci8),
                                      .busy(busy8), .done(done8), .s(s8), .co(co8));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic done_of(input int n);
        case (n)
            2:       return done2;
            4:       return done4;
            default: return done8;
        endcase
    endfunction

    function automatic logic [32:0] res_of(input int n);
        case (n)
            2:       return {24'h0, co2, s2};
            4:       return {16'h0, co4, s4};
            default: return {co8, s8};
        endcase
    endfunction

    // One start pulse; returns {co,s} and the edge count from accept to first visible done.
    task automatic run_op(input int n, input logic [31:0] av, input logic [31:0] bv, input logic civ,
                          output logic [32:0] res, output int lat);
        @(negedge clk);
        case (n)
            2:       begin a2 = av[7:0];  b2 = bv[7:0];  ci2 = civ; st2 = 1; end
            4:       begin a4 = av[15:0]; b4 = bv[15:0]; ci4 = civ; st4 = 1; end
            default: begin a8 = av;       b8 = bv;       ci8 = civ; st8 = 1; end
        endcase
        @(negedge clk);
        st2 = 0; st4 = 0; st8 = 0;
        lat = -1;
        res = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done_of(n)) begin
                lat = k;
                res = res_of(n);
                break;
            end
        end
    endtask

    logic [32:0] res;
    logic [32:0] gold;
    logic [31:0] ra, rb;
    logic        rc;
    int          lat;
    int          nbusy, ndone, dk[$];
    logic [15:0] s_at_done;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy4", busy4, 0); chk("rst_done4", done4, 0);
        chk("rst_s4", s4, 0);       chk("rst_co4", co4, 0);
        chk("rst_s2", s2, 0);       chk("rst_s8", s8, 0);
        rst = 0;

        // FFFF + 0001: done once, 5 edges after accept; busy for 5 cycles
        @(negedge clk);
        a4 = 16'hFFFF; b4 = 16'h0001; ci4 = 0; st4 = 1;
        @(negedge clk);
        st4 = 0;
        nbusy = 0; ndone = 0; lat = -1; s_at_done = 16'hDEAD;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (busy4) nbusy++;
            if (done4) begin ndone++; lat = k; s_at_done = s4; end
        end
        chk("lat_n4", 64'(lat), 5);
        chk("done_cnt_n4", 64'(ndone), 1);
        chk("busy_cycles_n4", 64'(nbusy), 5);
        chk("ffff_s", s_at_done, 16'h0000);
        chk("ffff_co", co4, 1);

        // Back-to-back results with no carry/nibble leakage
        run_op(4, 32'h1234, 32'h4321, 1, res, lat);
        chk("sum_1234_4321", res, 33'h05556);
        run_op(4, 32'h8000, 32'h8000, 0, res, lat);
        chk("sum_8000_8000", res, 33'h10000);

        // start and operand churn during RUN are ignored
        @(negedge clk);
        a4 = 16'h00FF; b4 = 16'h0001; ci4 = 0; st4 = 1;
        @(negedge clk); a4 = 16'hAAAA; b4 = 16'h5555; ci4 = 1;
        @(negedge clk); a4 = 16'h1234; b4 = 16'hFFFF;
        @(negedge clk); a4 = 16'h0000; b4 = 16'h7777;
        @(negedge clk); st4 = 0;
        ndone = 0; s_at_done = 16'hDEAD;
        for (int k = 4; k <= 12; k++) begin
            if (done4) begin ndone++; s_at_done = s4; end
            @(negedge clk);
        end
        chk("churn_done_cnt", 64'(ndone), 1);
        chk("churn_s", s_at_done, 16'h0100);
        chk("churn_co", co4, 0);

        // Reset on the third RUN cycle aborts everything
        @(negedge clk);
        a4 = 16'hFFFF; b4 = 16'hFFFF; ci4 = 1; st4 = 1;
        @(negedge clk); st4 = 0;
        @(negedge clk);
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        chk("abort_busy", busy4, 0); chk("abort_done", done4, 0);
        chk("abort_s", s4, 0);       chk("abort_co", co4, 0);
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done4 || busy4) ndone++;
        end
        chk("abort_quiet", 64'(ndone), 0);
        run_op(4, 32'h0002, 32'h0003, 0, res, lat);
        chk("after_abort_sum", res, 33'h00005);

        // Held start: a new accept every NIBBLES+2 cycles
        @(negedge clk);
        a4 = 16'h0F0F; b4 = 16'h00F1; ci4 = 0; st4 = 1;
        dk.delete();
        for (int k = 0; k <= 18; k++) begin
            @(negedge clk);
            if (done4) begin
                dk.push_back(k);
                chk("held_s", {co4, s4}, 17'h01000);
            end
        end
        st4 = 0;
        repeat (10) @(negedge clk);
        chk("held_cnt", 64'(dk.size()), 3);
        if (dk.size() == 3) begin
            chk("held_first", 64'(dk[0]), 5);
            chk("held_gap1", 64'(dk[1] - dk[0]), 6);
            chk("held_gap2", 64'(dk[2] - dk[1]), 6);
        end

        // Random requests against the bench's golden sum
        for (int i = 0; i < 200; i++) begin
            ra = {16'h0, 16'($urandom)}; rb = {16'h0, 16'($urandom)}; rc = 1'($urandom);
            gold = 33'(ra) + 33'(rb) + 33'(rc);
            run_op(4, ra, rb, rc, res, lat);
            chk($sformatf("rnd4_%0d", i), res, gold);
        end

        // NIBBLES = 2
        run_op(2, 32'hFF, 32'h01, 0, res, lat);
        chk("lat_n2", 64'(lat), 3);
        chk("n2_ff_01", res, 33'h100);
        run_op(2, 32'h12, 32'h34, 1, res, lat);
        chk("n2_12_34_c", res, 33'h047);
        for (int i = 0; i < 30; i++) begin
            ra = {24'h0, 8'($urandom)}; rb = {24'h0, 8'($urandom)}; rc = 1'($urandom);
            gold = 33'(ra) + 33'(rb) + 33'(rc);
            run_op(2, ra, rb, rc, res, lat);
            chk($sformatf("rnd2_%0d", i), res, gold);
        end

        // NIBBLES = 8
        run_op(8, 32'hFFFF_FFFF, 32'h0000_0001, 0, res, lat);
        chk("lat_n8", 64'(lat), 9);
        chk("n8_carry_all", res, 33'h1_0000_0000);
        for (int i = 0; i < 30; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom);
            gold = 33'(ra) + 33'(rb) + 33'(rc);
            run_op(8, ra, rb, rc, res, lat);
            chk($sformatf("rnd8_%0d", i), res, gold);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/add_seq_ctrl.md
Name: add_seq_ctrl

Overview:
- Multi-cycle sequencer that performs a wide addition, s = a + b + ci, by reusing one 4-bit adder (one fa4_mbit instance) over NIBBLES clock cycles, least-significant nibble first.
- The carry between nibbles is held in a register and chained from one cycle to the next.
- Uses a start/busy/done handshake.
- Sits between a requester (bus/test sequencer) and the shared 4-bit adder, trading latency for adder area.

Parameters:
- NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES; legal range 2..8.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  request pulse; sampled only in IDLE
- a  input  W  operand A; captured on accepted start
- b  input  W  operand B; captured on accepted start
- ci  input  1  carry-in; captured on accepted start
- busy  output  1  high while in RUN or DONE
- done  output  1  one-cycle completion pulse
- s  output  W  registered sum; stable from done until next accepted start
- co  output  1  registered carry-out of the top nibble

Behaviour:
- Reset: clk and rst are the only clock and reset. Reset is synchronous and active-high: on a rising edge of clk with rst=1, all state clears.
  - State goes to IDLE; busy=0, done=0, s=0, co=0.
  - Operand registers, carry register and nibble index are all 0.
  - rst has priority over every other input, including a mid-operation abort; no partial result survives.
- States: IDLE, RUN, DONE. State, index, carry and outputs are all registered.
- IDLE:
  - busy=0, done=0.
  - On start=1:
    - Latch a into opA and b into opB.
    - Carry register <= ci; idx <= 0.
    - s <= 0, co <= 0, so the previous result is cleared on accept.
    - Go to RUN.
- RUN (busy=1), each cycle:
  - Adder inputs: opA[4*idx+3 : 4*idx], opB[same], carry register.
  - On the clock edge, s[4*idx+3 : 4*idx] <= adder sum and carry <= adder co.
  - If idx == NIBBLES-1: co <= adder co and go to DONE. Otherwise idx <= idx+1.
- DONE: busy=1 and done=1 for exactly one cycle, then go to IDLE.
- Latency:
  - start accepted at edge E0.
  - RUN occupies the cycles after E0 through E_NIBBLES.
  - done is high in the cycle following edge E_NIBBLES+1.
  - With NIBBLES=4, done is visible 5 edges after the accepting edge.
- Back-to-back: start is not sampled in DONE. Minimum request spacing is NIBBLES+2 cycles.
- start while busy: ignored. Operands, index and carry are unaffected, and a/b changing during RUN has no effect.
- Width rule: result is (co,s) = a + b + ci, modulo 2^(W+1). No overflow flag.
- idx width is ceil(log2(NIBBLES)); idx never exceeds NIBBLES-1.
- No X propagation: every register has a defined reset value.

Test Plan:
- NIBBLES=4: a=16'hFFFF, b=16'h0001, ci=0, one-cycle start -> done pulses exactly once, 5 edges later; s=16'h0000, co=1; busy high for 5 cycles.
- a=16'h1234, b=16'h4321, ci=1 -> s=16'h5556, co=0. Then a=16'h8000, b=16'h8000, ci=0 -> s=16'h0000, co=1. The second result must not inherit stale nibbles or carry from the first.
- Start 16'h00FF+16'h0001; during RUN pulse start with a=16'hAAAA and change a/b every cycle -> result still s=16'h0100, co=0; only one done pulse.
- Start 16'hFFFF+16'hFFFF, ci=1; assert rst for one edge on the third RUN cycle -> next cycle busy=0, done=0, s=0, co=0, state IDLE. A following start with 16'h0002+16'h0003 gives s=16'h0005.
- Hold start=1 continuously with fixed operands 16'h0F0F+16'h00F1 -> a new operation is accepted every 6 cycles (NIBBLES+2); each gives s=16'h1000, co=0.
- 200 random {ci,a,b} requests, compared against golden a+b+ci in the bench. Repeat with NIBBLES=2 (W=8; done 3 edges after accept) and NIBBLES=8 (W=32).
